// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared types and constants for the framed boot-image receiver
//
// Purpose: state encoding, default sync marker and frame field offsets used by
//          prog_frame_rx and its word assembler.
// Ports:   none (package).
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } prog_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte offsets within a frame; the checksum byte sits at OFS_PAYLOAD + 4*LEN.
  localparam int OFS_SYNC    = 0;
  localparam int OFS_LEN_LO  = 1;
  localparam int OFS_LEN_HI  = 2;
  localparam int OFS_PAYLOAD = 3;

endpackage

// File: rtl/prog_word_asm.sv
// rtl/prog_word_asm.sv - little-endian byte-to-word assembler
//
// Purpose: collects four bytes into a 32-bit word, first byte in bits [7:0].
// Ports:
//   clk_i         in   1   system clock
//   rst_ni        in   1   synchronous active-low reset
//   clr_i         in   1   synchronous clear of byte count and partial word
//   en_i          in   1   byte_i is valid this cycle
//   byte_i        in   8   incoming byte
//   word_valid_o  out  1   high in the cycle the fourth byte is presented
//   word_o        out  32  completed word (valid with word_valid_o)
module prog_word_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  // Only three bytes are stored; the fourth is merged combinationally so the
  // owner can register the finished word in the same cycle it arrives.
  assign word_valid_o = en_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, sr_q};

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      sr_d  = 24'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_i, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/prog_frame_rx.sv
// rtl/prog_frame_rx.sv - framed boot-image receiver driving the ICCM write port
//
// Purpose: parses SYNC / LEN_LO / LEN_HI / payload / CSUM frames, writes one
//          little-endian word per four payload bytes, holds the core in reset
//          while programming and reports done/error.
// Ports:
//   clk_i      in   1       system clock
//   rst_ni     in   1       synchronous active-low reset
//   prog_i     in   1       programming mode request (level)
//   rx_dv_i    in   1       rx_byte_i valid strobe
//   rx_byte_i  in   8       received byte
//   we_o       out  1       one-cycle ICCM write strobe
//   addr_o     out  ADDR_W  word address of current write
//   wdata_o    out  32      write data
//   reset_o    out  1       core reset, active low
//   done_o     out  1       frame accepted (level)
//   err_o      out  1       frame rejected (level, sticky until next SYNC)
module prog_frame_rx
  import prog_pkg::*;
#(
  parameter int              ADDR_W    = 12,
  parameter int              DEPTH     = 1024,
  parameter logic [7:0]      SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int              TO_W      = 24,
  parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(1000000)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              reset_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TIMEOUT - TO_W'(1);

  prog_state_e       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              reset_q, reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        asm_clr, asm_en, word_valid;
  logic [31:0] word;
  logic [15:0] len_new, len_m1;
  logic [7:0]  sum_new;
  logic        in_frame, last_word;

  prog_word_asm u_word_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (asm_clr),
    .en_i         (asm_en),
    .byte_i       (rx_byte_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign in_frame  = state_q inside {LEN0, LEN1, DATA, CSUM};
  assign len_new   = {rx_byte_i, len_q[7:0]};
  assign len_m1    = len_q - 16'd1;
  // The address counter doubles as the word index within the frame.
  assign last_word = (addr_q == ADDR_W'(len_m1));
  assign sum_new   = sum_q + rx_byte_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    to_d    = to_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    asm_clr = 1'b0;
    asm_en  = 1'b0;

    // Advance the address the cycle after each write; saturate so the last
    // legal word address is never exceeded.
    if (we_q && (addr_q != ADDR_LAST)) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (in_frame) begin
      if (!prog_i) begin
        // Abort outranks any byte arriving in the same cycle.
        state_d = IDLE;
        err_d   = 1'b1;
        to_d    = '0;
        asm_clr = 1'b1;
      end else if (rx_dv_i) begin
        // A byte outranks a simultaneous timeout expiry.
        to_d  = '0;
        sum_d = sum_new;
        case (state_q)
          LEN0: begin
            len_d[7:0] = rx_byte_i;
            state_d    = LEN1;
          end
          LEN1: begin
            len_d = len_new;
            if ({1'b0, len_new} > DEPTH_L) state_d = ERR;
            else if (len_new == 16'd0)     state_d = CSUM;
            else                           state_d = DATA;
          end
          DATA: begin
            asm_en = 1'b1;
            if (word_valid) begin
              we_d    = 1'b1;
              wdata_d = word;
              if (last_word) state_d = CSUM;
            end
          end
          CSUM: state_d = (sum_new == 8'd0) ? DONE : ERR;
          default: ;
        endcase
      end else if (to_q == TO_LAST) begin
        state_d = ERR;
        to_d    = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      case (state_q)
        IDLE: begin
          // SYNC is only honoured in programming mode so stray line noise
          // outside it cannot start a frame that would immediately abort.
          if (prog_i && rx_dv_i && (rx_byte_i == SYNC_BYTE)) begin
            state_d = LEN0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            addr_d  = '0;
            sum_d   = 8'd0;
            to_d    = '0;
            asm_clr = 1'b1;
          end
        end
        DONE, ERR: if (!prog_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == DONE) done_d = 1'b1;
    if (state_d == ERR)  err_d  = 1'b1;

    case (state_d)
      IDLE:    reset_d = !prog_i;
      DONE:    reset_d = 1'b1;
      default: reset_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      addr_q  <= '0;
      sum_q   <= 8'd0;
      to_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      reset_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      to_q    <= to_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      reset_q <= reset_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign reset_o = reset_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_prog_frame_rx.sv
// tb/tb_prog_frame_rx.sv - directed scoreboard bench for prog_frame_rx
module tb_prog_frame_rx;

  localparam int          ADDR_W = 12;
  localparam int          TO     = 40;

  logic              clk;
  logic              rst_n;
  logic              prog;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic              reset_o;
  logic              done_o;
  logic              err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  run_sum;
  logic [43:0] exp_q[$];

  prog_frame_rx #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (1024),
    .TO_W    (24),
    .TIMEOUT (24'(TO))
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .prog_i    (prog),
    .rx_dv_i   (rx_dv),
    .rx_byte_i (rx_byte),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .reset_o   (reset_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_we: observed addr %0h data %0h expected no write", addr_o, wdata_o);
        end
      end else begin
        check("write_addr_data", {20'd0, addr_o, wdata_o}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_b(input logic [7:0] b, input logic exp_we);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    run_sum = run_sum + b;
    check("we_latency", 64'(we_o), 64'(exp_we));
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a);
    exp_q.push_back({a, w});
    send_b(w[7:0],   1'b0);
    send_b(w[15:8],  1'b0);
    send_b(w[23:16], 1'b0);
    send_b(w[31:24], 1'b1);
  endtask

  task automatic send_sync();
    send_b(8'hA5, 1'b0);
    run_sum = 8'd0;
  endtask

  task automatic prog_cycle();
    prog = 1'b0;
    @(negedge clk);
    prog = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    64'(we_o),    64'd0);
    check({tag, "_addr"},  64'(addr_o),  64'd0);
    check({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    check({tag, "_reset"}, 64'(reset_o), 64'd0);
    check({tag, "_done"},  64'(done_o),  64'd0);
    check({tag, "_err"},   64'(err_o),   64'd0);
  endtask

  task automatic two_word_frame(input logic [7:0] cs_adj);
    logic [7:0] cs;
    send_sync();
    send_b(8'h02, 1'b0);
    send_b(8'h00, 1'b0);
    send_word(32'h44332211, 12'd0);
    send_word(32'h88776655, 12'd1);
    cs = 8'h00 - run_sum + cs_adj;
    send_b(cs, 1'b0);
  endtask

  initial begin
    logic [7:0] cs;
    rst_n   = 1'b0;
    prog    = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    run_sum = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_core_released", 64'(reset_o), 64'd1);
    prog = 1'b1;
    @(negedge clk);
    check("prog_holds_core", 64'(reset_o), 64'd0);

    // Good two-word frame.
    two_word_frame(8'd0);
    check("t1_done", 64'(done_o), 64'd1);
    check("t1_err", 64'(err_o), 64'd0);
    check("t1_reset", 64'(reset_o), 64'd1);
    check("t1_writes_left", 64'(exp_q.size()), 64'd0);
    prog_cycle();

    // Same frame, bad checksum.
    two_word_frame(8'd1);
    check("t2_done", 64'(done_o), 64'd0);
    check("t2_err", 64'(err_o), 64'd1);
    check("t2_reset", 64'(reset_o), 64'd0);
    check("t2_writes_left", 64'(exp_q.size()), 64'd0);
    prog = 1'b0;
    @(negedge clk);
    check("t2_release", 64'(reset_o), 64'd1);
    check("t2_err_sticky", 64'(err_o), 64'd1);
    prog = 1'b1;
    @(negedge clk);

    // LEN = 1025 exceeds depth.
    send_sync();
    send_b(8'h01, 1'b0);
    send_b(8'h04, 1'b0);
    check("t3_err", 64'(err_o), 64'd1);
    check("t3_reset", 64'(reset_o), 64'd0);
    repeat (3) @(negedge clk);
    prog_cycle();

    // LEN = 0.
    send_sync();
    send_b(8'h00, 1'b0);
    send_b(8'h00, 1'b0);
    send_b(8'h00, 1'b0);
    check("t4_done", 64'(done_o), 64'd1);
    check("t4_err", 64'(err_o), 64'd0);
    prog_cycle();

    // Inter-byte timeout.
    send_sync();
    send_b(8'h01, 1'b0);
    send_b(8'h00, 1'b0);
    send_b(8'hAA, 1'b0);
    repeat (TO - 1) @(negedge clk);
    check("t5_err_before_timeout", 64'(err_o), 64'd0);
    @(negedge clk);
    check("t5_err_at_timeout", 64'(err_o), 64'd1);
    check("t5_reset", 64'(reset_o), 64'd0);
    prog = 1'b0;
    @(negedge clk);
    check("t5_release", 64'(reset_o), 64'd1);
    prog = 1'b1;
    @(negedge clk);

    // Abort mid-word; the word-completing byte arrives with the abort.
    send_sync();
    send_b(8'h02, 1'b0);
    send_b(8'h00, 1'b0);
    send_b(8'h11, 1'b0);
    send_b(8'h22, 1'b0);
    send_b(8'h33, 1'b0);
    @(negedge clk);
    prog    = 1'b0;
    rx_dv   = 1'b1;
    rx_byte = 8'h44;
    @(negedge clk);
    rx_dv = 1'b0;
    check("t6_no_write", 64'(we_o), 64'd0);
    check("t6_err", 64'(err_o), 64'd1);
    check("t6_reset", 64'(reset_o), 64'd1);
    check("t6_done", 64'(done_o), 64'd0);
    prog = 1'b1;
    @(negedge clk);
    send_sync();
    check("t6_sync_clears_err", 64'(err_o), 64'd0);
    send_b(8'h01, 1'b0);
    send_b(8'h00, 1'b0);
    send_word(32'h04030201, 12'd0);
    cs = 8'h00 - run_sum;
    send_b(cs, 1'b0);
    check("t6_restart_done", 64'(done_o), 64'd1);
    check("t6_writes_left", 64'(exp_q.size()), 64'd0);
    prog_cycle();

    // Reset in the middle of a word, coinciding with its last byte.
    send_sync();
    send_b(8'h01, 1'b0);
    send_b(8'h00, 1'b0);
    send_b(8'hDE, 1'b0);
    send_b(8'hAD, 1'b0);
    send_b(8'hBE, 1'b0);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = 8'hEF;
    rst_n   = 1'b0;
    @(negedge clk);
    rx_dv = 1'b0;
    check_reset_values("midrst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_writes_left", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
